id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: ID_stage

Interface
REQ-001 Parameter: NOP_IW, 32'h00000013, instruction word driven on iw_out for squashed/halted slots.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pc_in  input  32  PC of the instruction on iw_in, from the fetch stage.
REQ-005 iw_in  input  32  instruction word, cycle-aligned with pc_in.
REQ-006 rs1_reg, rs2_reg  output  5 each  register-file read addresses, combinational: iw_in[19:15], iw_in[24:20].
REQ-007 rs1_data_in, rs2_data_in  input  32 each  register-file read data, same cycle.
REQ-008 wb_enable, wb_reg, wb_data  input  1/5/32  writeback port, used for bypass.
REQ-009 jump_enable_out, jump_addr_out  output  1/32  redirect to the fetch stage, combinational.
REQ-010 ebreak_out  output  1  halt request to the fetch stage.
REQ-011 valid_out, pc_out, iw_out, rd_out, we_out, rs1_data_out, rs2_data_out, imm_out  output  1/32/32/5/1/32/32/32  registered ID/EX bundle.

Function
REQ-012 States: RUN, SQUASH, HALT; only a RUN-state slot is "live".
REQ-013 RUN: decode iw_in; on jump taken -> SQUASH; on EBREAK (32'h00100073) -> HALT; else stay RUN.
REQ-014 SQUASH: slot not live, no jump, no EBREAK detect; unconditionally -> RUN next cycle (exactly one slot discarded per redirect).
REQ-015 HALT: slot not live; ebreak_out=1 continuously; exits only on reset.
REQ-016 Operand bypass: if wb_enable && wb_reg!=0 && wb_reg==rsN, operand N = wb_data, else rsN_data_in; x0 reads always 0.
REQ-017 Immediate by opcode: I (0010011, 0000011, 1100111), S (0100011), B (1100011), U (0110111, 0010111), J (1101111); sign-extended to 32 bits; others 0.
REQ-018 Jumps (live slot only): JAL -> pc_in+immJ; JALR -> (op1+immI) with bit0 cleared; branch -> pc_in+immB when BEQ/BNE/BLT/BGE/BLTU/BGEU condition on bypassed operands holds; not-taken branch: jump_enable_out=0.
REQ-019 Address arithmetic is 32-bit modulo 2^32 (wrap-around, no trap).
REQ-020 we_out=1 for live OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR with rd!=0; else 0.
REQ-021 Unknown opcode in live slot: passed with valid_out=1, we_out=0, imm_out=0, no jump.
REQ-022 ID/EX register latency one cycle; non-live slot -> valid_out=0, we_out=0, iw_out=NOP_IW, rd_out=0, other fields don't-care but driven 0.
REQ-023 jump_enable_out and ebreak_out never both asserted from one slot; ebreak_out for EBREAK asserts in the decode cycle and stays high from the next cycle in HALT.

Reset
REQ-024 Reset -> state SQUASH (first fetched slot after reset is discarded).
REQ-025 Reset -> valid_out=0, we_out=0, pc_out=0, iw_out=NOP_IW, rd_out=0, rs1_data_out=0, rs2_data_out=0, imm_out=0, ebreak_out=0, jump_enable_out=0.
REQ-026 Reset asserted in any state, including HALT or mid-SQUASH, takes priority over all transitions.

Configuration
REQ-027 Macro ID_SQUASH_CNT_EN defined: output squash_count[31:0], reset 0, +1 per non-live slot in SQUASH state, saturates at 32'hFFFFFFFF.
REQ-028 Macro undefined: squash_count port and counter absent; all other behaviour identical.

Verification
REQ-029 Reset released, pc_in=0/4/8 with ADDI stream -> slot pc 0 squashed (valid_out=0), pc 4 appears on pc_out one cycle later with valid_out=1.
REQ-030 JAL x1,+16 at pc 0x100 -> jump_enable_out=1, jump_addr_out=0x110 same cycle; next slot (0x104) valid_out=0; rd_out=1, we_out=1.
REQ-031 BEQ x2,x3,-8 at pc 0x20, rs2 data=5, wb_enable=1 wb_reg=3 wb_data=5 -> jump_addr_out=0x18 taken; with wb_data=6 -> not taken.
REQ-032 JALR x0,x5,3 with x5=0xFFFFFFFE -> jump_addr_out=0x00000000 (wrap, bit0 cleared), we_out=0.
REQ-033 EBREAK at pc 0x40 -> ebreak_out high from that cycle, valid_out=0 thereafter; reset -> ebreak_out=0, state SQUASH.
REQ-034 With ID_SQUASH_CNT_EN: reset then two taken jumps -> squash_count=3.

Source files
------------

// File: rtl/id_stage.sv
// Decode stage: operand bypass, immediate generation, jump resolution, ID/EX register.
// Optional squash counter output enabled by defining ID_SQUASH_CNT_EN.
module id_stage #(
    parameter logic [31:0] NOP_IW = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    output logic [4:0]  rs1_reg,
    output logic [4:0]  rs2_reg,
    input  logic [31:0] rs1_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_enable,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        jump_enable_out,
    output logic [31:0] jump_addr_out,
    output logic        ebreak_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [4:0]  rd_out,
    output logic        we_out,
    output logic [31:0] rs1_data_out,
    output logic [31:0] rs2_data_out,
    output logic [31:0] imm_out
`ifdef ID_SQUASH_CNT_EN
    ,
    output logic [31:0] squash_count
`endif
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [31:0] EBREAK_IW = 32'h00100073;

    typedef enum logic [1:0] {
        RUN,
        SQUASH,
        HALT
    } state_t;

    state_t state, next_state;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic [31:0] op1, op2;
    logic        live;
    logic        is_ebreak;
    logic        wr_class;
    logic        br_cond;
    logic        jump;
    logic [31:0] target;

    assign opcode  = iw_in[6:0];
    assign funct3  = iw_in[14:12];
    assign rd      = iw_in[11:7];
    assign rs1_reg = iw_in[19:15];
    assign rs2_reg = iw_in[24:20];

    assign imm_i = {{20{iw_in[31]}}, iw_in[31:20]};
    assign imm_s = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
    assign imm_b = {{19{iw_in[31]}}, iw_in[31], iw_in[7],
                    iw_in[30:25], iw_in[11:8], 1'b0};
    assign imm_u = {iw_in[31:12], 12'b0};
    assign imm_j = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12],
                    iw_in[20], iw_in[30:21], 1'b0};

    // x0 reads zero; a matching writeback overrides the register file.
    always_comb begin
        op1 = rs1_data_in;
        op2 = rs2_data_in;
        if (rs1_reg == 5'd0)
            op1 = '0;
        else if (wb_enable && wb_reg == rs1_reg)
            op1 = wb_data;
        if (rs2_reg == 5'd0)
            op2 = '0;
        else if (wb_enable && wb_reg == rs2_reg)
            op2 = wb_data;
    end

    always_comb begin
        imm      = '0;
        wr_class = 1'b0;
        unique case (opcode)
            OPC_OP:     wr_class = 1'b1;
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR: begin
                imm      = imm_i;
                wr_class = 1'b1;
            end
            OPC_STORE:  imm = imm_s;
            OPC_BRANCH: imm = imm_b;
            OPC_LUI,
            OPC_AUIPC: begin
                imm      = imm_u;
                wr_class = 1'b1;
            end
            OPC_JAL: begin
                imm      = imm_j;
                wr_class = 1'b1;
            end
            default: begin
                imm      = '0;
                wr_class = 1'b0;
            end
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        unique case (funct3)
            3'b000:  br_cond = (op1 == op2);
            3'b001:  br_cond = (op1 != op2);
            3'b100:  br_cond = ($signed(op1) < $signed(op2));
            3'b101:  br_cond = ($signed(op1) >= $signed(op2));
            3'b110:  br_cond = (op1 < op2);
            3'b111:  br_cond = (op1 >= op2);
            default: br_cond = 1'b0;
        endcase
    end

    assign live      = (state == RUN);
    assign is_ebreak = (iw_in == EBREAK_IW);

    always_comb begin
        jump   = 1'b0;
        target = '0;
        unique case (1'b1)
            opcode == OPC_JAL: begin
                jump   = 1'b1;
                target = pc_in + imm_j;
            end
            opcode == OPC_JALR: begin
                jump   = 1'b1;
                target = (op1 + imm_i) & 32'hFFFF_FFFE;
            end
            opcode == OPC_BRANCH: begin
                jump   = br_cond;
                target = pc_in + imm_b;
            end
            default: begin
                jump   = 1'b0;
                target = '0;
            end
        endcase
    end

    assign jump_enable_out = live && jump;
    assign jump_addr_out   = live ? target : '0;
    assign ebreak_out      = (state == HALT) || (live && is_ebreak);

    always_ff @(posedge clk) begin
        if (reset)
            state <= SQUASH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (jump)
                    next_state = SQUASH;
                else if (is_ebreak)
                    next_state = HALT;
            end
            SQUASH:  next_state = RUN;
            HALT:    next_state = HALT;
            default: next_state = SQUASH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !live) begin
            valid_out    <= 1'b0;
            pc_out       <= '0;
            iw_out       <= NOP_IW;
            rd_out       <= '0;
            we_out       <= 1'b0;
            rs1_data_out <= '0;
            rs2_data_out <= '0;
            imm_out      <= '0;
        end else begin
            valid_out    <= 1'b1;
            pc_out       <= pc_in;
            iw_out       <= iw_in;
            rd_out       <= rd;
            we_out       <= wr_class && (rd != 5'd0);
            rs1_data_out <= op1;
            rs2_data_out <= op2;
            imm_out      <= imm;
        end
    end

`ifdef ID_SQUASH_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            squash_count <= '0;
        else if (state == SQUASH && squash_count != 32'hFFFF_FFFF)
            squash_count <= squash_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, squash after redirect, bypass,
// immediates, jumps with wrap-around, EBREAK halt and reset recovery.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [31:0] rs1_data_in;
    logic [31:0] rs2_data_in;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        jump_enable_out;
    logic [31:0] jump_addr_out;
    logic        ebreak_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic [4:0]  rd_out;
    logic        we_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] imm_out;
`ifdef ID_SQUASH_CNT_EN
    logic [31:0] squash_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADDI   = 32'h00100093;
    localparam logic [31:0] JAL16  = 32'h010000EF;
    localparam logic [31:0] BEQ_M8 = 32'hFE310CE3;
    localparam logic [31:0] JALR3  = 32'h00328067;
    localparam logic [31:0] SW_M4  = 32'hFE20AE23;
    localparam logic [31:0] LUI5   = 32'h123452B7;
    localparam logic [31:0] BADOP  = 32'hFFFFFFFF;
    localparam logic [31:0] EBRK   = 32'h00100073;

    id_stage dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .iw_in           (iw_in),
        .rs1_reg         (rs1_reg),
        .rs2_reg         (rs2_reg),
        .rs1_data_in     (rs1_data_in),
        .rs2_data_in     (rs2_data_in),
        .wb_enable       (wb_enable),
        .wb_reg          (wb_reg),
        .wb_data         (wb_data),
        .jump_enable_out (jump_enable_out),
        .jump_addr_out   (jump_addr_out),
        .ebreak_out      (ebreak_out),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .iw_out          (iw_out),
        .rd_out          (rd_out),
        .we_out          (we_out),
        .rs1_data_out    (rs1_data_out),
        .rs2_data_out    (rs2_data_out),
        .imm_out         (imm_out)
`ifdef ID_SQUASH_CNT_EN
        ,
        .squash_count    (squash_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] iw);
        pc_in = pc;
        iw_in = iw;
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        pc_in       = '0;
        iw_in       = NOP;
        rs1_data_in = '0;
        rs2_data_in = '0;
        wb_enable   = 1'b0;
        wb_reg      = '0;
        wb_data     = '0;
        step();
        step();
        reset = 1'b0;

        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_we", {31'd0, we_out}, 32'd0);
        check("rst_pc", pc_out, 32'd0);
        check("rst_iw", iw_out, NOP);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        check("rst_imm", imm_out, 32'd0);
        check("rst_rs1d", rs1_data_out, 32'd0);
        check("rst_rs2d", rs2_data_out, 32'd0);
        check("rst_ebrk", {31'd0, ebreak_out}, 32'd0);

        // First slot after reset is discarded; x0 ignores writeback.
        wb_enable   = 1'b1;
        wb_reg      = 5'd0;
        wb_data     = 32'hDEAD;
        rs1_data_in = 32'h1234;
        drive(32'h0, ADDI);
        check("sq_jump", {31'd0, jump_enable_out}, 32'd0);
        check("rs1_reg", {27'd0, rs1_reg}, 32'd0);
        check("rs2_reg", {27'd0, rs2_reg}, 32'd1);
        step();
        check("sq0_valid", {31'd0, valid_out}, 32'd0);
        check("sq0_iw", iw_out, NOP);
        drive(32'h4, ADDI);
        step();
        check("pc4_valid", {31'd0, valid_out}, 32'd1);
        check("pc4_pc", pc_out, 32'h4);
        check("pc4_iw", iw_out, ADDI);
        check("pc4_rd", {27'd0, rd_out}, 32'd1);
        check("pc4_we", {31'd0, we_out}, 32'd1);
        check("pc4_imm", imm_out, 32'd1);
        check("pc4_x0", rs1_data_out, 32'd0);
        drive(32'h8, ADDI);
        step();
        check("pc8_pc", pc_out, 32'h8);
        wb_enable = 1'b0;

        // JAL x1,+16 at 0x100
        drive(32'h100, JAL16);
        check("jal_en", {31'd0, jump_enable_out}, 32'd1);
        check("jal_addr", jump_addr_out, 32'h110);
        check("jal_ebrk", {31'd0, ebreak_out}, 32'd0);
        step();
        check("jal_valid", {31'd0, valid_out}, 32'd1);
        check("jal_rd", {27'd0, rd_out}, 32'd1);
        check("jal_we", {31'd0, we_out}, 32'd1);
        check("jal_imm", imm_out, 32'd16);
        drive(32'h104, ADDI);
        check("jal_sq_jump", {31'd0, jump_enable_out}, 32'd0);
        step();
        check("jal_sq_valid", {31'd0, valid_out}, 32'd0);
        check("jal_sq_we", {31'd0, we_out}, 32'd0);

        // BEQ x2,x3,-8 at 0x20, x3 forwarded from writeback
        rs1_data_in = 32'd5;
        rs2_data_in = 32'd9;
        wb_enable   = 1'b1;
        wb_reg      = 5'd3;
        wb_data     = 32'd5;
        drive(32'h20, BEQ_M8);
        check("beq_rs1", {27'd0, rs1_reg}, 32'd2);
        check("beq_rs2", {27'd0, rs2_reg}, 32'd3);
        check("beq_t_en", {31'd0, jump_enable_out}, 32'd1);
        check("beq_t_addr", jump_addr_out, 32'h18);
        step();
        check("beq_imm", imm_out, 32'hFFFFFFF8);
        check("beq_op2", rs2_data_out, 32'd5);
        check("beq_op1", rs1_data_out, 32'd5);
        check("beq_we", {31'd0, we_out}, 32'd0);
        drive(32'h24, ADDI);
        step();
        check("beq_sq_valid", {31'd0, valid_out}, 32'd0);
        wb_data = 32'd6;
        drive(32'h20, BEQ_M8);
        check("beq_nt_en", {31'd0, jump_enable_out}, 32'd0);
        step();
        check("beq_nt_valid", {31'd0, valid_out}, 32'd1);
        check("beq_nt_op2", rs2_data_out, 32'd6);
        wb_enable = 1'b0;

        // JALR x0,x5,3 with wrap-around
        rs1_data_in = 32'hFFFFFFFE;
        drive(32'h24, JALR3);
        check("jalr_en", {31'd0, jump_enable_out}, 32'd1);
        check("jalr_addr", jump_addr_out, 32'h0);
        step();
        check("jalr_we", {31'd0, we_out}, 32'd0);
        check("jalr_rd", {27'd0, rd_out}, 32'd0);
        check("jalr_imm", imm_out, 32'd3);
        drive(32'h28, ADDI);
        step();
        check("jalr_sq", {31'd0, valid_out}, 32'd0);

        // Unknown opcode, S-type and U-type immediates
        drive(32'h0, BADOP);
        check("bad_jump", {31'd0, jump_enable_out}, 32'd0);
        step();
        check("bad_valid", {31'd0, valid_out}, 32'd1);
        check("bad_we", {31'd0, we_out}, 32'd0);
        check("bad_imm", imm_out, 32'd0);
        drive(32'h4, SW_M4);
        step();
        check("sw_imm", imm_out, 32'hFFFFFFFC);
        check("sw_we", {31'd0, we_out}, 32'd0);
        drive(32'h8, LUI5);
        step();
        check("lui_imm", imm_out, 32'h12345000);
        check("lui_rd", {27'd0, rd_out}, 32'd5);
        check("lui_we", {31'd0, we_out}, 32'd1);

        // EBREAK halts until reset
        drive(32'h40, EBRK);
        check("ebrk_now", {31'd0, ebreak_out}, 32'd1);
        check("ebrk_jump", {31'd0, jump_enable_out}, 32'd0);
        step();
        check("halt_ebrk", {31'd0, ebreak_out}, 32'd1);
        drive(32'h44, ADDI);
        check("halt_jump", {31'd0, jump_enable_out}, 32'd0);
        step();
        check("halt_valid", {31'd0, valid_out}, 32'd0);
        check("halt_ebrk2", {31'd0, ebreak_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("hrst_ebrk", {31'd0, ebreak_out}, 32'd0);
        check("hrst_valid", {31'd0, valid_out}, 32'd0);
        drive(32'h0, ADDI);
        step();
        check("hrst_sq", {31'd0, valid_out}, 32'd0);
        drive(32'h4, ADDI);
        step();
        check("hrst_run", {31'd0, valid_out}, 32'd1);

`ifdef ID_SQUASH_CNT_EN
        drive(32'h100, JAL16);
        step();
        drive(32'h104, ADDI);
        step();
        drive(32'h110, JAL16);
        step();
        drive(32'h114, ADDI);
        step();
        check("sq_count", squash_count, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
